// File: rtl/gsram_pkg.sv
// Shared constants and types for the generic SRAM port arbiter.
package gsram_pkg;

  localparam int unsigned ABITS_DEFAULT = 14;
  localparam int unsigned NREQ_MAX      = 8;
  localparam int unsigned IDW           = $clog2(NREQ_MAX);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } gsram_state_t;

  // One in-flight read per SRAM port: which requester gets the Q bit next cycle.
  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
  } rsp_slot_t;

endpackage

// File: rtl/rr_pick2.sv
// Round-robin picker: first two requesters at or after ptr, as one-hot winners.
module rr_pick2
  import gsram_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] win0,
  output logic [NREQ-1:0] win1,
  output logic            vld0,
  output logic            vld1
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] idx;

  // Scan requesters in priority order starting at ptr; keep the first two hits.
  always_comb begin
    win0 = '0;
    win1 = '0;
    vld0 = 1'b0;
    vld1 = 1'b0;
    idx  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = PW'((32'(ptr) + i) % NREQ);
      if (req[idx]) begin
        if (!vld0) begin
          win0[idx] = 1'b1;
          vld0      = 1'b1;
        end else if (!vld1) begin
          win1[idx] = 1'b1;
          vld1      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/gsram_port_arbiter.sv
// Two-port arbiter for the 1-bit-wide generic SRAM: zero-sweep after reset/clear,
// then up to two round-robin accesses per cycle with read data one cycle after grant.
module gsram_port_arbiter
  import gsram_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned ABITS = ABITS_DEFAULT
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  clr_req,
  output logic                  init_done,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ-1:0]       req_we,
  input  logic [NREQ*ABITS-1:0] req_addr,
  input  logic [NREQ-1:0]       req_wdata,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [NREQ-1:0]       rsp_rdata,
  output logic [ABITS-1:0]      A0,
  output logic [ABITS-1:0]      A1,
  output logic                  D0,
  output logic                  D1,
  output logic                  WE0,
  output logic                  WE1,
  output logic                  CE0,
  output logic                  CE1,
  input  logic                  Q0,
  input  logic                  Q1
);

  localparam int unsigned KW = ABITS - 1;

  gsram_state_t     state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic             done_q, done_d;
  logic [IDW-1:0]   rr_q, rr_d;

  logic [NREQ-1:0]  win0, win1;
  logic             wv0, wv1;
  logic [IDW-1:0]   id0, id1;
  logic [ABITS-1:0] waddr0, waddr1;
  logic             wwe0, wwe1, wwd0, wwd1;
  logic             conflict, sweep, run_ok, gnt0, gnt1;

  logic [ABITS-1:0] a0_q, a1_q;
  logic             d0_q, d1_q;
  rsp_slot_t        slot0_q, slot1_q, slot0_d, slot1_d;

  function automatic logic [IDW-1:0] rr_inc(input logic [IDW-1:0] x);
    rr_inc = ((32'(x) + 32'd1) >= NREQ) ? '0 : x + IDW'(1);
  endfunction

  rr_pick2 #(
    .NREQ (NREQ)
  ) u_pick (
    .req  (req_valid),
    .ptr  (rr_q),
    .win0 (win0),
    .win1 (win1),
    .vld0 (wv0),
    .vld1 (wv1)
  );

  // Decode one-hot winners into requester id and access fields.
  always_comb begin
    id0    = '0;
    id1    = '0;
    waddr0 = '0;
    waddr1 = '0;
    wwe0   = 1'b0;
    wwe1   = 1'b0;
    wwd0   = 1'b0;
    wwd1   = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win0[i]) begin
        id0    = IDW'(i);
        waddr0 = req_addr[i*ABITS +: ABITS];
        wwe0   = req_we[i];
        wwd0   = req_wdata[i];
      end
      if (win1[i]) begin
        id1    = IDW'(i);
        waddr1 = req_addr[i*ABITS +: ABITS];
        wwe1   = req_we[i];
        wwd1   = req_wdata[i];
      end
    end
  end

  // Same-address pair with any write: only port0 goes this cycle.
  assign conflict  = wv0 & wv1 & (waddr0 == waddr1) & (wwe0 | wwe1);
  assign sweep     = (state_q == CLEAR) & ~RST;
  assign run_ok    = (state_q == RUN) & ~clr_req & ~RST;
  assign gnt0      = run_ok & wv0;
  assign gnt1      = run_ok & wv1 & ~conflict;
  assign req_ready = ({NREQ{gnt0}} & win0) | ({NREQ{gnt1}} & win1);
  assign init_done = done_q;

  // SRAM port drive: sweep writes, granted accesses, otherwise idle holding A/D.
  always_comb begin
    CE0 = sweep | gnt0;
    CE1 = sweep | gnt1;
    WE0 = sweep | (gnt0 & wwe0);
    WE1 = sweep | (gnt1 & wwe1);
    A0  = a0_q;
    A1  = a1_q;
    D0  = d0_q;
    D1  = d1_q;
    if (sweep) begin
      A0 = {k_q, 1'b0};
      A1 = {k_q, 1'b1};
      D0 = 1'b0;
      D1 = 1'b0;
    end else begin
      if (gnt0) begin
        A0 = waddr0;
        D0 = wwd0;
      end
      if (gnt1) begin
        A1 = waddr1;
        D1 = wwd1;
      end
    end
  end

  // Next state: sweep counter, init flag and round-robin pointer.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    done_d  = done_q;
    rr_d    = rr_q;
    unique case (state_q)
      CLEAR: begin
        if (clr_req) begin
          k_d = '0;
        end else if (&k_q) begin
          state_d = RUN;
          done_d  = 1'b1;
          k_d     = '0;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      RUN: begin
        if (clr_req) begin
          state_d = CLEAR;
          k_d     = '0;
          done_d  = 1'b0;
        end else if (wv0) begin
          if (conflict)  rr_d = id1;
          else if (wv1)  rr_d = rr_inc(id1);
          else           rr_d = rr_inc(id0);
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // Granted reads remember which requester owns each port's Q next cycle.
  always_comb begin
    slot0_d     = '0;
    slot1_d     = '0;
    slot0_d.vld = gnt0 & ~wwe0;
    slot0_d.id  = id0;
    slot1_d.vld = gnt1 & ~wwe1;
    slot1_d.id  = id1;
  end

  // State, hold and response pipe registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= CLEAR;
      k_q     <= '0;
      done_q  <= 1'b0;
      rr_q    <= '0;
      a0_q    <= '0;
      a1_q    <= '0;
      d0_q    <= 1'b0;
      d1_q    <= 1'b0;
      slot0_q <= '0;
      slot1_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      done_q  <= done_d;
      rr_q    <= rr_d;
      a0_q    <= A0;
      a1_q    <= A1;
      d0_q    <= D0;
      d1_q    <= D1;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
    end
  end

  // Route each port's read bit to the requester that issued it.
  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (slot0_q.vld && (slot0_q.id == IDW'(i))) begin
        rsp_valid[i] = 1'b1;
        rsp_rdata[i] = Q0;
      end else if (slot1_q.vld && (slot1_q.id == IDW'(i))) begin
        rsp_valid[i] = 1'b1;
        rsp_rdata[i] = Q1;
      end
    end
  end

endmodule
